// File: rtl/cabac_pkg.sv
// rtl/cabac_pkg.sv - shared types and constants for the CABAC bin scheduler
package cabac_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_BYTE = 2'd2
  } sched_state_t;

  localparam logic signed [3:0] BITS_NEEDED_INIT = 4'sb1000;
  localparam int                BYTE_BITS        = 8;

endpackage

// File: rtl/cabac_bits_tracker.sv
// rtl/cabac_bits_tracker.sv - bits_needed register, byte-need test and byte lane selection
module cabac_bits_tracker
  import cabac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bypass,
  input  logic [2:0] k,
  input  logic [2:0] renorm_bits,
  input  logic       issue,
  output logic       need_byte,
  output logic [1:0] lane
);

  logic signed [3:0] bits_needed;
  logic signed [4:0] bn_ext;
  logic        [4:0] step;
  logic signed [4:0] idx;

  assign bn_ext    = {bits_needed[3], bits_needed};
  assign step      = bypass ? {2'b00, k} : {2'b00, renorm_bits};
  assign idx       = bn_ext + $signed(step);
  assign need_byte = ~idx[4];
  // -bits_needed-1 is the bitwise complement; only the low two bits can be nonzero when a byte loads
  assign lane      = bypass ? ~bits_needed[1:0] : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_needed <= BITS_NEEDED_INIT;
    end else if (issue) begin
      bits_needed <= need_byte ? (idx[3:0] - 4'(BYTE_BITS)) : idx[3:0];
    end
  end

endmodule

// File: rtl/cabac_bin_sched.sv
// rtl/cabac_bin_sched.sv - CABAC bin scheduler: splits commands into decoder ops and feeds bytes
// Optional stat_bins/stat_bytes counters enabled by CABAC_SCHED_STATS_EN.
module cabac_bin_sched
  import cabac_pkg::*;
#(
  parameter int MAX_BINS = 3,
  parameter int NB_W     = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [7:0]          cmd_pstate,
  input  logic                cmd_bypass,
  input  logic [NB_W-1:0]     cmd_numbins,
  input  logic                byte_valid,
  output logic                byte_ready,
  input  logic [7:0]          byte_data,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [1:0]          dec_n_bin,
  output logic                dec_bypass,
  output logic [7:0]          dec_pstate,
  output logic                dec_byte_load,
  output logic [7:0]          dec_byte,
  output logic [1:0]          dec_byte_lane,
  input  logic [2:0]          renorm_bits,
  input  logic [MAX_BINS-1:0] dec_bins,
  output logic                bin_valid,
  output logic [MAX_BINS-1:0] bin_data,
  output logic [2:0]          bin_cnt,
  output logic                busy,
  output logic [31:0]         stat_bins,
  output logic [31:0]         stat_bytes
);

  sched_state_t        state, state_nxt;
  logic [7:0]          pstate_q;
  logic                bypass_q;
  logic [NB_W-1:0]     remaining;
  logic [2:0]          k;
  logic                last_op;
  logic                issue;
  logic                need_byte;
  logic [1:0]          trk_lane;
  logic [MAX_BINS-1:0] bins_masked;

  always_comb begin
    if (!bypass_q) begin
      k = 3'd1;
    end else if (remaining < NB_W'(MAX_BINS)) begin
      k = remaining[2:0];
    end else begin
      k = 3'(MAX_BINS);
    end
  end

  assign last_op = (remaining == NB_W'(k));

  cabac_bits_tracker u_trk (
    .clk         (clk),
    .rst_n       (rst_n),
    .bypass      (bypass_q),
    .k           (k),
    .renorm_bits (renorm_bits),
    .issue       (issue),
    .need_byte   (need_byte),
    .lane        (trk_lane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    dec_valid  = 1'b0;
    byte_ready = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = RUN;
      end
      RUN, WAIT_BYTE: begin
        if (remaining == '0) begin
          state_nxt = IDLE;
        end else if (dec_ready && (!need_byte || byte_valid)) begin
          issue      = 1'b1;
          dec_valid  = 1'b1;
          byte_ready = need_byte;
          state_nxt  = last_op ? IDLE : RUN;
        end else if (need_byte && !byte_valid) begin
          state_nxt = WAIT_BYTE;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign dec_n_bin     = dec_valid ? 2'(k - 3'd1) : 2'b00;
  assign dec_bypass    = dec_valid & bypass_q;
  assign dec_pstate    = dec_valid ? pstate_q : 8'h00;
  assign dec_byte_load = byte_ready;
  assign dec_byte      = byte_ready ? byte_data : 8'h00;
  assign dec_byte_lane = byte_ready ? trk_lane : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q  <= 8'h00;
      bypass_q  <= 1'b0;
      remaining <= '0;
    end else if (state == IDLE && cmd_valid) begin
      pstate_q  <= cmd_pstate;
      bypass_q  <= cmd_bypass;
      remaining <= cmd_numbins;
    end else if (issue) begin
      remaining <= remaining - NB_W'(k);
    end
  end

  // Lanes at or above k carry no bin this op and are returned as zero
  always_comb begin
    bins_masked = '0;
    for (int i = 0; i < MAX_BINS; i++) begin
      bins_masked[i] = dec_bins[i] & (i < int'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_valid <= 1'b0;
      bin_data  <= '0;
      bin_cnt   <= 3'd0;
    end else begin
      bin_valid <= issue;
      if (issue) begin
        bin_data <= bins_masked;
        bin_cnt  <= k;
      end
    end
  end

`ifdef CABAC_SCHED_STATS_EN
  logic [31:0] bins_q;
  logic [31:0] bytes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bins_q  <= 32'd0;
      bytes_q <= 32'd0;
    end else begin
      if (issue) bins_q <= bins_q + 32'(k);
      if (byte_ready) bytes_q <= bytes_q + 32'd1;
    end
  end

  assign stat_bins  = bins_q;
  assign stat_bytes = bytes_q;
`else
  assign stat_bins  = 32'd0;
  assign stat_bytes = 32'd0;
`endif

endmodule
